// File: rtl/alu.sv
// 16-bit eight-function ALU with a registered result and a zero flag.
// All eight operations are computed combinationally and captured every rising edge.
module alu (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [2:0]  control,
  output logic [15:0] result,
  output logic        isZero
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_SLL = 3'b100,
    OP_SRL = 3'b101,
    OP_SRA = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  op_e         op;
  logic        big;
  logic [3:0]  amt;
  logic [15:0] sra;
  logic [15:0] nxt;

  assign op  = op_e'(control);
  // Any amount of 16 or more shifts every original bit out of the word.
  assign big = |in2[15:4];
  assign amt = in2[3:0];
  assign sra = $signed(in1) >>> amt;

  always_comb begin
    nxt = 16'h0000;
    case (op)
      OP_AND: nxt = in1 & in2;
      OP_OR:  nxt = in1 | in2;
      OP_ADD: nxt = in1 + in2;
      OP_SUB: nxt = in1 - in2;
      OP_SLL: nxt = big ? 16'h0000 : (in1 << amt);
      OP_SRL: nxt = big ? 16'h0000 : (in1 >> amt);
      OP_SRA: nxt = big ? {16{in1[15]}} : sra;
      OP_SLT: nxt = ($signed(in1) < $signed(in2)) ? 16'h0001 : 16'h0000;
      default: nxt = 16'h0000;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) result <= 16'h0000;
    else          result <= nxt;
  end

  assign isZero = (result == 16'h0000);

endmodule

// File: tb/tb_alu.sv
// Bench for alu: integer-arithmetic reference model, per-cycle compare, directed corners.
module tb_alu;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in1 = '0;
  logic [15:0] in2 = '0;
  logic [2:0]  control = '0;
  logic [15:0] result;
  logic        isZero;

  int npass = 0;
  int ntot  = 0;
  logic        cmp_en = 1'b0;
  logic [15:0] exp_q = 16'h0000;

  alu dut (
    .clock(clock), .reset_n(reset_n), .in1(in1), .in2(in2),
    .control(control), .result(result), .isZero(isZero)
  );

  always #5 clock = ~clock;

  // Reference computed with plain integer arithmetic rather than bit operators.
  function automatic logic [15:0] model(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    longint ua, ub, sa, sb, d, q;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return 16'((ua + ub) % 65536);
      3'd3: return 16'((ua - ub + 65536) % 65536);
      3'd4: return (ub >= 16) ? 16'h0000 : 16'((ua * (longint'(1) << ub)) % 65536);
      3'd5: return (ub >= 16) ? 16'h0000 : 16'(ua / (longint'(1) << ub));
      3'd6: begin
        d = longint'(1) << ((ub >= 16) ? 16 : ub);
        q = (sa >= 0) ? (sa / d) : -((-sa + d - 1) / d);
        return 16'(q);
      end
      default: return (sa < sb) ? 16'h0001 : 16'h0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    ntot++;
    if (act === req) npass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Expected register: follows the spec's capture/reset rules, fed by the model.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) exp_q <= 16'h0000;
    else          exp_q <= model(control, in1, in2);
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("model_result", result, exp_q);
      check("model_iszero", {15'd0, isZero}, {15'd0, exp_q == 16'h0000});
    end
  end

  typedef struct {
    logic [2:0]  c;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] e;
  } vec_t;

  vec_t dirs[] = '{
    '{3'd0, 16'hAAAA, 16'h5555, 16'h0000}, '{3'd0, 16'hAAAA, 16'hFFFF, 16'hAAAA},
    '{3'd1, 16'hAAAA, 16'h5555, 16'hFFFF}, '{3'd1, 16'h0000, 16'h0000, 16'h0000},
    '{3'd2, 16'hFFFF, 16'h0001, 16'h0000}, '{3'd2, 16'hFFFF, 16'hFFFF, 16'hFFFE},
    '{3'd2, 16'h7FFF, 16'h7FFF, 16'hFFFE}, '{3'd2, 16'h7FFF, 16'h0001, 16'h8000},
    '{3'd3, 16'hFFFF, 16'h0001, 16'hFFFE}, '{3'd3, 16'h0001, 16'h0001, 16'h0000},
    '{3'd3, 16'h7FFF, 16'h0001, 16'h7FFE}, '{3'd3, 16'h0000, 16'h0001, 16'hFFFF},
    '{3'd4, 16'h0001, 16'h0001, 16'h0002}, '{3'd4, 16'h8000, 16'h0001, 16'h0000},
    '{3'd4, 16'h5555, 16'h0001, 16'hAAAA}, '{3'd4, 16'h0001, 16'h000F, 16'h8000},
    '{3'd5, 16'h8000, 16'h0001, 16'h4000}, '{3'd5, 16'hAAAA, 16'h0001, 16'h5555},
    '{3'd5, 16'h8000, 16'h000F, 16'h0001}, '{3'd6, 16'h8000, 16'h0001, 16'hC000},
    '{3'd6, 16'hAAAA, 16'h0001, 16'hD555}, '{3'd6, 16'h8000, 16'h000F, 16'hFFFF},
    '{3'd6, 16'h0001, 16'h0001, 16'h0000}, '{3'd4, 16'h0001, 16'd20,   16'h0000},
    '{3'd6, 16'h8000, 16'd20,   16'hFFFF}, '{3'd5, 16'hFFFF, 16'h0100, 16'h0000},
    '{3'd4, 16'h1234, 16'h0000, 16'h1234}, '{3'd6, 16'h9234, 16'h0000, 16'h9234},
    '{3'd7, 16'h0000, 16'h0000, 16'h0000}, '{3'd7, 16'h0000, 16'h0001, 16'h0001},
    '{3'd7, 16'h0001, 16'h0000, 16'h0000}, '{3'd7, 16'h0001, 16'hFFFF, 16'h0000},
    '{3'd7, 16'h8000, 16'h7FFF, 16'h0001}
  };

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    // Pin the model against hand-computed values.
    check("pin_add", model(3'd2, 16'h7FFF, 16'h0001), 16'h8000);
    check("pin_sra", model(3'd6, 16'hAAAA, 16'h0001), 16'hD555);
    check("pin_sra_big", model(3'd6, 16'h8000, 16'd20), 16'hFFFF);
    check("pin_slt", model(3'd7, 16'h0001, 16'hFFFF), 16'h0000);
    check("pin_sub", model(3'd3, 16'h0000, 16'h0001), 16'hFFFF);

    #2;
    check("reset_result", result, 16'h0000);
    check("reset_iszero", {15'd0, isZero}, 16'h0001);
    @(negedge clock);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    foreach (dirs[i]) begin
      @(negedge clock);
      control = dirs[i].c; in1 = dirs[i].a; in2 = dirs[i].b;
      @(posedge clock); #1;
      check($sformatf("dir%0d", i), result, dirs[i].e);
      check($sformatf("dir%0d_z", i), {15'd0, isZero}, {15'd0, dirs[i].e == 16'h0000});
    end

    // Asynchronous reset and one-cycle latency.
    @(negedge clock);
    control = 3'd2; in1 = 16'h0001; in2 = 16'h0001;
    @(posedge clock); #1;
    check("lat_add", result, 16'h0002);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst", result, 16'h0000);
    check("async_rst_z", {15'd0, isZero}, 16'h0001);
    @(posedge clock); #1;
    check("rst_hold", result, 16'h0000);
    @(negedge clock); #1 reset_n = 1'b1;
    #1;
    check("rel_wait", result, 16'h0000);
    @(posedge clock); #1;
    check("rel_cap", result, 16'h0002);
    #1 control = 3'd0; in1 = 16'h0000; in2 = 16'h0000;
    #1;
    check("hold_old", result, 16'h0002);
    @(posedge clock); #1;
    check("new_cap", result, 16'h0000);

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 2000; n++) begin
      @(negedge clock);
      control = 3'($urandom_range(0, 7));
      in1 = pick();
      in2 = (control >= 3'd4 && control <= 3'd6 && $urandom_range(0, 3) != 0)
            ? 16'($urandom_range(0, 20)) : pick();
    end
    @(negedge clock);
    @(negedge clock);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 16-bit, eight-function integer ALU for the 16-bit datapath.
- Performs AND, OR, ADD, SUB, logical left shift, logical right shift, arithmetic right shift and signed set-less-than, selected by a 3-bit control code.
- The result is registered on the rising clock edge and drives a zero flag used for branch decisions.

Parameters:
- None. Data width is fixed at 16 bits and the control code is fixed at 3 bits.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- in1  input  16  operand A; value to be shifted for shift operations
- in2  input  16  operand B; shift amount for shift operations
- control  input  3  operation select
- result  output  16  registered operation result
- isZero  output  1  high when result == 16'h0000

Behaviour:
- Control encoding:
  - 3'b000: in1 & in2
  - 3'b001: in1 | in2
  - 3'b010: in1 + in2
  - 3'b011: in1 - in2
  - 3'b100: in1 << in2
  - 3'b101: in1 >> in2, logical, zero fill
  - 3'b110: in1 >>> in2, arithmetic, fill with in1[15]
  - 3'b111: 16'h0001 if signed(in1) < signed(in2), else 16'h0000
- Add/sub arithmetic:
  - Two's complement, wraps modulo 2^16.
  - No carry, overflow or exception output; the overflow bit is discarded.
  - Example: 7FFF+0001 = 8000.
- SLT compares both operands as signed 16-bit values and must use a true signed compare, not the sign of the difference. Example: 8000 slt 7FFF = 1.
- Shift amount uses the full unsigned 16-bit value of in2:
  - in2 of 0 passes in1 through unchanged.
  - in2 >= 16 gives 0000 for SLL/SRL.
  - in2 >= 16 gives all bits equal to in1[15] for SRA.
- Timing:
  - The combinational result of the current in1/in2/control is captured into the result register on every rising clock edge.
  - Latency is 1 cycle; there is no enable or handshake.
- isZero is combinational from the registered result, so it is valid in the same cycle result is.
- Reset:
  - reset_n low immediately (asynchronously) forces result = 0000, and hence isZero = 1.
  - The register stays cleared while reset_n is low.
  - The first capture happens on the first rising edge after reset_n goes high.
- Reset asserted mid-operation discards the pending result; no residual state exists.
- All control codes are defined; no illegal encodings.

Test Plan:
- Logic (captured one clock after inputs are applied):
  - AND: AAAA & 5555 -> 0000, isZero=1.
  - AND: AAAA & FFFF -> AAAA.
  - OR: AAAA | 5555 -> FFFF.
  - OR: 0000 | 0000 -> 0000, isZero=1.
- Add:
  - FFFF+0001 -> 0000, isZero=1.
  - FFFF+FFFF -> FFFE.
  - 7FFF+7FFF -> FFFE.
  - 7FFF+0001 -> 8000.
- Sub:
  - FFFF-0001 -> FFFE.
  - 0001-0001 -> 0000, isZero=1.
  - 7FFF-0001 -> 7FFE.
  - 0000-0001 -> FFFF.
- Shifts:
  - SLL 0001<<1 -> 0002; 8000<<1 -> 0000; 5555<<1 -> AAAA; 0001<<15 -> 8000.
  - SRL 8000>>1 -> 4000; AAAA>>1 -> 5555; 8000>>15 -> 0001.
  - SRA 8000>>>1 -> C000; AAAA>>>1 -> D555; 8000>>>15 -> FFFF; 0001>>>1 -> 0000.
  - Shift amount >= 16: SLL 0001<<20 -> 0000; SRA 8000>>>20 -> FFFF.
- SLT:
  - 0000 slt 0000 -> 0000.
  - 0000 slt 0001 -> 0001.
  - 0001 slt 0000 -> 0000.
  - 0001 slt FFFF -> 0000 (signed compare).
  - 8000 slt 7FFF -> 0001.
- Reset and latency:
  - Load ADD 0001+0001 and clock, so result = 0002.
  - Drop reset_n between clock edges -> result = 0000 and isZero = 1 immediately, without waiting for a clock edge.
  - Release reset_n -> result stays 0000 until the next rising edge, then shows 0002.
  - After a new input change, result holds its old value until that edge.
